// File: rtl/insn_fetch_sequencer.sv
// Instruction fetch sequencer: pops opcode, optional ModRM, displacement and
// immediate bytes from a prefetch FIFO and presents them as decoded fields.
module insn_fetch_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic        complete,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic [7:0]  opcode,
  input  logic        desc_has_modrm,
  input  logic [1:0]  desc_imm_size,
  output logic [7:0]  modrm,
  output logic [15:0] displacement,
  output logic [15:0] immediate
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_DECODE, S_MODRM, S_DISP, S_IMM
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  modrm_q, modrm_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] imm_q, imm_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  disp_len_q, disp_len_d;
  logic [1:0]  imm_len_q, imm_len_d;
  logic        complete_q, complete_d;
  logic [1:0]  imm_len_dec;
  logic [1:0]  disp_len_dec;

  assign busy         = (state_q != S_IDLE);
  assign complete     = complete_q;
  assign opcode       = opcode_q;
  assign modrm        = modrm_q;
  assign displacement = disp_q;
  assign immediate    = imm_q;

  // Pop whenever a byte is wanted and one is available.
  assign fifo_rd_en = ~fifo_empty &
                      ((state_q == S_OPCODE) || (state_q == S_MODRM) ||
                       (state_q == S_DISP)   || (state_q == S_IMM));

  // Decoder immediate size with the reserved encoding folded to "none".
  assign imm_len_dec = (desc_imm_size == 2'd3) ? 2'd0 : desc_imm_size;

  // Displacement length implied by the ModRM byte at the FIFO head.
  always_comb begin
    disp_len_dec = 2'd0;
    if (fifo_rd_data[7:6] == 2'b01)
      disp_len_dec = 2'd1;
    else if (fifo_rd_data[7:6] == 2'b10)
      disp_len_dec = 2'd2;
    else if ((fifo_rd_data[7:6] == 2'b00) && (fifo_rd_data[2:0] == 3'b110))
      disp_len_dec = 2'd2;
  end

  // Next-state, field capture and completion logic; flush overrides all.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    modrm_d    = modrm_q;
    disp_d     = disp_q;
    imm_d      = imm_q;
    cnt_d      = cnt_q;
    disp_len_d = disp_len_q;
    imm_len_d  = imm_len_q;
    complete_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_OPCODE;
          opcode_d = 8'h00;
          modrm_d  = 8'h00;
          disp_d   = 16'h0000;
          imm_d    = 16'h0000;
        end
      end
      S_OPCODE: begin
        if (fifo_rd_en) begin
          opcode_d = fifo_rd_data;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_len_d = imm_len_dec;
        cnt_d     = 2'd0;
        if (desc_has_modrm)
          state_d = S_MODRM;
        else if (imm_len_dec != 2'd0)
          state_d = S_IMM;
        else begin
          state_d    = S_IDLE;
          complete_d = 1'b1;
        end
      end
      S_MODRM: begin
        if (fifo_rd_en) begin
          modrm_d    = fifo_rd_data;
          disp_len_d = disp_len_dec;
          cnt_d      = 2'd0;
          if (disp_len_dec != 2'd0)
            state_d = S_DISP;
          else if (imm_len_q != 2'd0)
            state_d = S_IMM;
          else begin
            state_d    = S_IDLE;
            complete_d = 1'b1;
          end
        end
      end
      S_DISP: begin
        if (fifo_rd_en) begin
          // Byte 0 is written sign-extended; byte 1 then replaces the top half.
          if (cnt_q == 2'd0)
            disp_d = {{8{fifo_rd_data[7]}}, fifo_rd_data};
          else
            disp_d[15:8] = fifo_rd_data;
          if ((cnt_q + 2'd1) == disp_len_q) begin
            cnt_d = 2'd0;
            if (imm_len_q != 2'd0)
              state_d = S_IMM;
            else begin
              state_d    = S_IDLE;
              complete_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_IMM: begin
        if (fifo_rd_en) begin
          if (cnt_q == 2'd0)
            imm_d = {{8{fifo_rd_data[7]}}, fifo_rd_data};
          else
            imm_d[15:8] = fifo_rd_data;
          if ((cnt_q + 2'd1) == imm_len_q) begin
            cnt_d      = 2'd0;
            state_d    = S_IDLE;
            complete_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d    = S_IDLE;
      opcode_d   = 8'h00;
      modrm_d    = 8'h00;
      disp_d     = 16'h0000;
      imm_d      = 16'h0000;
      cnt_d      = 2'd0;
      disp_len_d = 2'd0;
      imm_len_d  = 2'd0;
      complete_d = 1'b0;
    end
  end

  // State, result and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      opcode_q   <= 8'h00;
      modrm_q    <= 8'h00;
      disp_q     <= 16'h0000;
      imm_q      <= 16'h0000;
      cnt_q      <= 2'd0;
      disp_len_q <= 2'd0;
      imm_len_q  <= 2'd0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      modrm_q    <= modrm_d;
      disp_q     <= disp_d;
      imm_q      <= imm_d;
      cnt_q      <= cnt_d;
      disp_len_q <= disp_len_d;
      imm_len_q  <= imm_len_d;
      complete_q <= complete_d;
    end
  end

endmodule

// File: tb/tb_insn_fetch_sequencer.sv
// Directed bench for insn_fetch_sequencer with a small FIFO model.
module tb_insn_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic        busy;
  logic        complete;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [7:0]  opcode;
  logic        desc_has_modrm;
  logic [1:0]  desc_imm_size;
  logic [7:0]  modrm;
  logic [15:0] displacement;
  logic [15:0] immediate;

  int tests_run;
  int tests_failed;

  logic [7:0] fmem [16];
  int         rp, wp;
  logic       starve;

  int flush_cyc, restart_cyc, s_lo, s_hi;
  int done_cyc, npop, ncomp, npop_win;

  insn_fetch_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .flush          (flush),
    .busy           (busy),
    .complete       (complete),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_empty     (fifo_empty),
    .opcode         (opcode),
    .desc_has_modrm (desc_has_modrm),
    .desc_imm_size  (desc_imm_size),
    .modrm          (modrm),
    .displacement   (displacement),
    .immediate      (immediate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_rd_data = fmem[rp[3:0]];
  assign fifo_empty   = (rp == wp) || starve;

  // FIFO model: pop one byte just after each edge on which the DUT read.
  always @(posedge clk) begin
    logic en;
    en = fifo_rd_en;
    #1;
    if (en) rp = rp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_fifo(input logic [7:0] b0, b1, b2, b3, b4, b5, input int n);
    fmem[0] = b0; fmem[1] = b1; fmem[2] = b2;
    fmem[3] = b3; fmem[4] = b4; fmem[5] = b5;
    for (int i = 6; i < 16; i++) fmem[i] = 8'h00;
    rp = 0;
    wp = n;
  endtask

  // Start at cycle 0 and observe cycles 1..budget at the falling edge.
  task automatic run_fetch(input int budget);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    done_cyc = -1; npop = 0; ncomp = 0; npop_win = 0;
    for (int n = 1; n <= budget; n++) begin
      starve = (n >= s_lo) && (n <= s_hi);
      flush  = (n == flush_cyc);
      start  = (n == restart_cyc);
      @(negedge clk);
      if (fifo_rd_en) begin
        npop++;
        if ((n >= s_lo) && (n <= s_hi)) npop_win++;
      end
      if (complete) begin
        ncomp++;
        if (done_cyc < 0) done_cyc = n;
      end
      @(posedge clk);
      #2;
    end
    starve = 1'b0;
    flush  = 1'b0;
    start  = 1'b0;
    flush_cyc = -1; restart_cyc = -1; s_lo = -1; s_hi = -1;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    start = 1'b0; flush = 1'b0; starve = 1'b0;
    desc_has_modrm = 1'b0; desc_imm_size = 2'd0;
    flush_cyc = -1; restart_cyc = -1; s_lo = -1; s_hi = -1;
    load_fifo(8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    reset_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_complete", {31'd0, complete}, 0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("rst_fields", {opcode, modrm, displacement}, 0);
    chk("rst_imm", {16'd0, immediate}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Opcode-only fetch.
    run_fetch(6);
    chk("op_done_cyc", done_cyc, 3);
    chk("op_npop", npop, 1);
    chk("op_pulse", ncomp, 1);
    chk("op_opcode", {24'd0, opcode}, 32'h90);
    chk("op_idle", {31'd0, busy}, 0);

    // imm8 fetch with sign extension; a start while busy is ignored.
    load_fifo(8'h04, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    desc_has_modrm = 1'b0; desc_imm_size = 2'd1;
    restart_cyc = 2;
    run_fetch(7);
    chk("imm8_done_cyc", done_cyc, 4);
    chk("imm8_pulse", ncomp, 1);
    chk("imm8_imm", {16'd0, immediate}, 32'hFFF0);
    chk("imm8_opcode", {24'd0, opcode}, 32'h04);
    chk("imm8_restart_ignored", {31'd0, busy}, 0);

    // Full fetch: ModRM, disp16, imm16.
    load_fifo(8'h81, 8'h86, 8'h34, 8'h12, 8'hCD, 8'hAB, 6);
    desc_has_modrm = 1'b1; desc_imm_size = 2'd2;
    run_fetch(11);
    chk("full_done_cyc", done_cyc, 8);
    chk("full_npop", npop, 6);
    chk("full_modrm", {24'd0, modrm}, 32'h86);
    chk("full_disp", {16'd0, displacement}, 32'h1234);
    chk("full_imm", {16'd0, immediate}, 32'hABCD);
    chk("full_hold_opcode", {24'd0, opcode}, 32'h81);

    // Same fetch starved for three cycles in DISP.
    load_fifo(8'h81, 8'h86, 8'h34, 8'h12, 8'hCD, 8'hAB, 6);
    s_lo = 4; s_hi = 6;
    run_fetch(14);
    chk("starve_done_cyc", done_cyc, 11);
    chk("starve_win_pops", npop_win, 0);
    chk("starve_disp", {16'd0, displacement}, 32'h1234);
    chk("starve_imm", {16'd0, immediate}, 32'hABCD);

    // disp8 via mod=01, sign-extended, no immediate.
    load_fifo(8'h8B, 8'h46, 8'hFE, 8'h00, 8'h00, 8'h00, 3);
    desc_has_modrm = 1'b1; desc_imm_size = 2'd0;
    run_fetch(7);
    chk("d8_done_cyc", done_cyc, 5);
    chk("d8_disp", {16'd0, displacement}, 32'hFFFE);
    chk("d8_imm", {16'd0, immediate}, 32'h0000);

    // Reserved immediate size behaves as none.
    load_fifo(8'hC3, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    desc_has_modrm = 1'b0; desc_imm_size = 2'd3;
    run_fetch(6);
    chk("rsv_done_cyc", done_cyc, 3);
    chk("rsv_npop", npop, 1);

    // Flush on the final IMM pop: no complete, results cleared.
    load_fifo(8'h05, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 3);
    desc_has_modrm = 1'b0; desc_imm_size = 2'd2;
    flush_cyc = 4;
    run_fetch(7);
    chk("flush_ncomp", ncomp, 0);
    chk("flush_imm", {16'd0, immediate}, 0);
    chk("flush_opcode", {24'd0, opcode}, 0);
    chk("flush_busy", {31'd0, busy}, 0);
    load_fifo(8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    desc_imm_size = 2'd0;
    run_fetch(6);
    chk("post_flush_done", done_cyc, 3);
    chk("post_flush_opcode", {24'd0, opcode}, 32'h90);

    // Flush and start together in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", {31'd0, busy}, 0);
    chk("flush_start_opcode", {24'd0, opcode}, 0);

    // Asynchronous reset in MODRM.
    load_fifo(8'h81, 8'h86, 8'h34, 8'h12, 8'hCD, 8'hAB, 6);
    desc_has_modrm = 1'b1; desc_imm_size = 2'd2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("modrm_busy_pre", {31'd0, busy}, 1);
    chk("modrm_rd_en_pre", {31'd0, fifo_rd_en}, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("arst_opcode", {24'd0, opcode}, 0);
    chk("arst_complete", {31'd0, complete}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    load_fifo(8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    desc_has_modrm = 1'b0; desc_imm_size = 2'd0;
    run_fetch(6);
    chk("post_rst_done", done_cyc, 3);
    chk("post_rst_npop", npop, 1);
    chk("post_rst_opcode", {24'd0, opcode}, 32'h90);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
